// File: rtl/packet_mem_to_gmii_tx_if.sv
// Bundles the packet-store read port and the GMII-style transmit side of
// packet_mem_to_gmii_tx. The transmitter is the master of the store read bus.
interface packet_mem_to_gmii_tx_if #(
    parameter int pADDR_W = 11,
    parameter int pLEN_W  = 11
);
    logic                iempty;
    logic [pLEN_W-1:0]   ilen_pac;
    logic [7:0]          ir_data;
    logic [pADDR_W-1:0]  or_addr;
    logic                opop;
    logic [7:0]          otx_d;
    logic                otx_en;
    logic                otx_er;
    logic                obusy;

    modport master (
        input  iempty, ilen_pac, ir_data,
        output or_addr, opop, otx_d, otx_en, otx_er, obusy
    );

    modport slave (
        output iempty, ilen_pac, ir_data,
        input  or_addr, opop, otx_d, otx_en, otx_er, obusy
    );
endinterface

// File: rtl/packet_mem_to_gmii_tx.sv
// Reads buffered packets from the packet store and sends them as GMII-style
// frames (preamble, SFD, payload, inter-frame gap), then pops them.
module packet_mem_to_gmii_tx #(
    parameter int pADDR_W  = 11,
    parameter int pLEN_W   = 11,
    parameter int pPRE_LEN = 7,
    parameter int pIFG     = 12,
    parameter int pMAX_LEN = 1518
) (
    input  logic                     iclk,
    input  logic                     i_rst,
    packet_mem_to_gmii_tx_if.master  bus
);

    localparam int CW = (pLEN_W > 8) ? pLEN_W : 8;
    localparam logic [CW-1:0]     PRE_LAST = CW'(pPRE_LEN - 1);
    localparam logic [CW-1:0]     IFG_LAST = CW'(pIFG - 1);
    localparam logic [pLEN_W:0]   LEN_MAX  = (pLEN_W + 1)'(pMAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
        ST_IFG  = 3'd4,
        ST_DROP = 3'd5
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [pLEN_W-1:0]   r_len;
    logic [pADDR_W-1:0]  r_base;
    logic [pADDR_W-1:0]  r_addr;
    logic [7:0]          r_tx_d;
    logic                r_tx_en;
    logic                r_tx_er;
    logic                r_pop;
    logic                r_busy;

    state_t              w_state_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [pLEN_W-1:0]   w_len_nxt;
    logic [pADDR_W-1:0]  w_base_nxt;
    logic [pADDR_W-1:0]  w_addr_nxt;
    logic [7:0]          w_tx_d;
    logic                w_tx_en;
    logic                w_pop;
    logic                w_len_bad;
    logic                w_data_last;

    assign w_len_bad   = (bus.ilen_pac == {pLEN_W{1'b0}}) ||
                         ({1'b0, bus.ilen_pac} > LEN_MAX);
    assign w_data_last = (r_cnt == (CW'(r_len) - CW'(1)));

    // Next-state and next-output logic; the address is fetched one state ahead
    // so the read data lines up with the registered transmit byte.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_base_nxt  = r_base;
        w_addr_nxt  = r_addr;
        w_tx_d      = 8'h00;
        w_tx_en     = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.iempty) begin
                    w_cnt_nxt = {CW{1'b0}};
                    if (w_len_bad) begin
                        w_state_nxt = ST_DROP;
                    end else begin
                        w_len_nxt   = bus.ilen_pac;
                        w_state_nxt = ST_PRE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRE: begin
                w_tx_en = 1'b1;
                w_tx_d  = 8'h55;
                if (r_cnt == PRE_LAST) begin
                    w_cnt_nxt   = {CW{1'b0}};
                    w_addr_nxt  = r_base;
                    w_state_nxt = ST_SFD;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_SFD: begin
                w_tx_en     = 1'b1;
                w_tx_d      = 8'hD5;
                w_cnt_nxt   = {CW{1'b0}};
                w_addr_nxt  = r_base + pADDR_W'(1);
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_tx_en    = 1'b1;
                w_tx_d     = bus.ir_data;
                w_addr_nxt = r_addr + pADDR_W'(1);
                if (w_data_last) begin
                    w_pop       = 1'b1;
                    w_base_nxt  = r_base + pADDR_W'(r_len);
                    w_cnt_nxt   = {CW{1'b0}};
                    w_state_nxt = ST_IFG;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_IFG: begin
                if (r_cnt == IFG_LAST) begin
                    w_cnt_nxt   = {CW{1'b0}};
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DROP: begin
                // One gap cycle lets the store present its next head packet.
                w_pop       = 1'b1;
                w_base_nxt  = r_base + pADDR_W'(bus.ilen_pac);
                w_cnt_nxt   = IFG_LAST;
                w_state_nxt = ST_IFG;
            end
            default: begin
                w_cnt_nxt   = {CW{1'b0}};
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge iclk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_len   <= {pLEN_W{1'b0}};
            r_base  <= {pADDR_W{1'b0}};
            r_addr  <= {pADDR_W{1'b0}};
            r_tx_d  <= 8'h00;
            r_tx_en <= 1'b0;
            r_tx_er <= 1'b0;
            r_pop   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_base  <= w_base_nxt;
            r_addr  <= w_addr_nxt;
            r_tx_d  <= w_tx_d;
            r_tx_en <= w_tx_en;
            r_tx_er <= 1'b0;
            r_pop   <= w_pop;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.or_addr = r_addr;
    assign bus.opop    = r_pop;
    assign bus.otx_d   = r_tx_d;
    assign bus.otx_en  = r_tx_en;
    assign bus.otx_er  = r_tx_er;
    assign bus.obusy   = r_busy;

endmodule

// File: tb/tb_packet_mem_to_gmii_tx.sv
// Directed bench for packet_mem_to_gmii_tx: a small packet-store model feeds
// lengths and memory bytes; frames on the transmit side are checked byte by byte.
module tb_packet_mem_to_gmii_tx;

    localparam int AW = 11;
    localparam int LW = 11;

    logic iclk  = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 iclk = ~iclk;

    packet_mem_to_gmii_tx_if #(.pADDR_W(AW), .pLEN_W(LW)) bus ();

    packet_mem_to_gmii_tx #(
        .pADDR_W(AW), .pLEN_W(LW), .pPRE_LEN(7), .pIFG(12), .pMAX_LEN(1518)
    ) dut (
        .iclk  (iclk),
        .i_rst (rst_n),
        .bus   (bus.master)
    );

    // Packet store model: memory, length FIFO and pop handling.
    logic [7:0]    mem    [0:2047];
    logic [LW-1:0] pk_len [0:15];
    int head = 0;
    int tail = 0;

    assign bus.iempty   = (head == tail);
    assign bus.ilen_pac = pk_len[head[3:0]];

    always @(posedge iclk) begin
        bus.ir_data <= mem[bus.or_addr];
        if (bus.opop && (head != tail)) head <= head + 1;
    end

    function automatic logic [7:0] mem_exp(input int a);
        int w;
        w = a % 2048;
        return 8'(w) ^ 8'(w >> 8);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic push(input int len);
        pk_len[tail[3:0]] = LW'(len);
        tail = tail + 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge iclk);
        rst_n = 1'b1;
        @(negedge iclk);
    endtask

    // Called at a negedge; waits for a frame and checks its whole contents.
    task automatic capture_frame(input string tag, input int exp_len, input int exp_base,
                                 output int idle_cyc);
        int n_en, n_hdr_bad, n_data_bad, n_pop, pop_idx, n_er;
        logic [7:0] exp_b;
        idle_cyc = 0; n_en = 0; n_hdr_bad = 0; n_data_bad = 0;
        n_pop = 0; pop_idx = -1; n_er = 0;
        while (!bus.otx_en && idle_cyc < 200) begin
            if (bus.opop) n_pop++;
            @(negedge iclk);
            idle_cyc++;
        end
        check({tag, "_start"}, (idle_cyc < 200), 1);
        while (bus.otx_en && n_en < 2000) begin
            if (n_en < 7)       exp_b = 8'h55;
            else if (n_en == 7) exp_b = 8'hD5;
            else                exp_b = mem_exp(exp_base + n_en - 8);
            if (bus.otx_d !== exp_b) begin
                if (n_en < 8) n_hdr_bad++;
                else          n_data_bad++;
            end
            if (bus.opop) begin
                n_pop++;
                pop_idx = n_en;
            end
            if (bus.otx_er) n_er++;
            @(negedge iclk);
            n_en++;
        end
        check({tag, "_en_cycles"}, n_en, exp_len + 8);
        check({tag, "_hdr_bad"}, n_hdr_bad, 0);
        check({tag, "_data_bad"}, n_data_bad, 0);
        check({tag, "_pop_count"}, n_pop, 1);
        check({tag, "_pop_idx"}, pop_idx, exp_len + 7);
        check({tag, "_tx_er"}, n_er, 0);
    endtask

    task automatic observe(input int ncyc, output int pops, output int ens);
        pops = 0; ens = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (bus.opop)   pops++;
            if (bus.otx_en) ens++;
            @(negedge iclk);
        end
    endtask

    initial begin
        int idle, pops, ens, n, t;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'(i >> 8);
        for (int i = 0; i < 16; i++) pk_len[i] = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge iclk);
        check("rst_tx_en", bus.otx_en, 1'b0);
        check("rst_tx_d", bus.otx_d, 8'h00);
        check("rst_tx_er", bus.otx_er, 1'b0);
        check("rst_pop", bus.opop, 1'b0);
        check("rst_addr", bus.or_addr, 11'd0);
        check("rst_busy", bus.obusy, 1'b0);
        rst_n = 1'b1;
        @(negedge iclk);

        // Single 60-byte packet, then a 1-byte packet that must read from 60.
        push(60);
        capture_frame("single", 60, 0, idle);
        check("single_latency", idle, 2);
        push(1);
        capture_frame("min_len", 1, 60, idle);

        // Reset during byte 10 of a 64-byte packet.
        do_reset();
        push(64);
        n = 0; t = 0; pops = 0;
        while (n < 18 && t < 300) begin
            if (bus.otx_en) n++;
            if (bus.opop)   pops++;
            @(negedge iclk);
            t++;
        end
        check("rstmid_reach_byte10", (t < 300), 1);
        check("rstmid_data_byte10", bus.otx_d, 8'h0A);
        rst_n = 1'b0;
        #1;
        check("rstmid_tx_en", bus.otx_en, 1'b0);
        check("rstmid_addr", bus.or_addr, 11'd0);
        check("rstmid_pop", bus.opop, 1'b0);
        check("rstmid_no_pop_before", pops, 0);
        repeat (3) @(negedge iclk);
        check("rstmid_store_kept", bus.iempty, 1'b0);
        rst_n = 1'b1;
        capture_frame("rstmid_retx", 64, 0, idle);

        // Back-to-back 64 and 100 from a clean base.
        do_reset();
        push(64);
        push(100);
        capture_frame("b2b_a", 64, 0, idle);
        capture_frame("b2b_b", 100, 64, idle);
        check("b2b_gap", idle, 13);

        // Drops: zero length and oversize, then a valid packet.
        push(0);
        observe(40, pops, ens);
        check("drop0_pop", pops, 1);
        check("drop0_en", ens, 0);
        push(1600);
        observe(40, pops, ens);
        check("drop1600_pop", pops, 1);
        check("drop1600_en", ens, 0);
        push(64);
        capture_frame("post_drop", 64, 164 + 1600, idle);

        // Address wrap past 2047, then confirm the wrapped base.
        push(250);
        capture_frame("wrap", 250, 1828, idle);
        push(1);
        capture_frame("wrap_base", 1, 30, idle);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
